// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Result, carry-out and signed overflow are registered on completion and held until the next one.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             bit_s;
    logic             carry_nxt;

    // Operands shift right each RUN cycle, so bit 0 is always the bit in flight.
    assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        // NOTE: every target gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    work_d  = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                work_d  = {bit_s, work_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = {bit_s, work_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    ovf_d   = carry_q ^ carry_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, captured when start accepted.
REQ-006 b  input  WIDTH  operand B, captured when start accepted.
REQ-007 sub  input  1  mode, captured when start accepted: 0 = A+B, 1 = A-B.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  single-cycle pulse: result registers just updated.
REQ-010 sum  output  WIDTH  result, registered, modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-012 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-013 FSM states IDLE, RUN, DONE; exactly one active.
REQ-014 IDLE: start=1 -> capture a, b, sub; carry register <= sub; bit counter <= 0; go RUN.
REQ-015 IDLE: start=0 -> stay IDLE.
REQ-016 RUN: one bit per cycle, LSB first; bit i = a[i] XOR b'[i] XOR carry, where b' = b when sub=0, ~b when sub=1; carry <= majority(a[i], b'[i], carry).
REQ-017 RUN: partial-sum bits accumulate in an internal shift/working register, not in sum.
REQ-018 RUN: counter increments each cycle; after bit WIDTH-1 processed -> go DONE.
REQ-019 Transition to DONE loads sum, cout (final carry) and ovf (carry into MSB XOR carry out of MSB) in the same edge.
REQ-020 DONE lasts exactly one cycle; done=1 only in DONE; busy=0 in DONE.
REQ-021 DONE: start=1 -> accepted exactly as in IDLE (back-to-back operation, no idle gap); else go IDLE.
REQ-022 Latency: start accepted on edge E -> done=1 in the cycle following edge E+WIDTH; busy=1 for exactly WIDTH cycles.
REQ-023 start while RUN is ignored; in-flight operands and mode unaffected; changes on a/b/sub during RUN have no effect.
REQ-024 sum, cout, ovf hold last result from completion until the next completion, including through RUN and IDLE.
REQ-025 No combinational path from inputs to any output; all outputs registered.
REQ-026 Counter width = ceil(log2(WIDTH))+1 bits; no wrap before completion for any legal WIDTH.

Reset
REQ-027 rst=1 at an edge -> state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter and carry cleared.
REQ-028 rst takes priority over start and over all FSM transitions.
REQ-029 rst mid-RUN aborts the operation; no done pulse; result outputs read 0 on the next cycle.
REQ-030 First start accepted is the one sampled on the first edge with rst=0.

Verification (WIDTH=8 unless stated)
REQ-031 add a=8'h0F b=8'h01 -> sum=8'h10 cout=0 ovf=0; done exactly 8 cycles after the start edge; busy high 8 cycles.
REQ-032 add a=8'hFF b=8'h01 -> sum=8'h00 cout=1 ovf=0; add a=8'h7F b=8'h01 -> sum=8'h80 cout=0 ovf=1.
REQ-033 sub a=8'h05 b=8'h07 -> sum=8'hFE cout=0 ovf=0; sub a=8'h80 b=8'h01 -> sum=8'h7F cout=1 ovf=1.
REQ-034 start pulsed with a=8'h11 b=8'h22 during RUN of 8'h01+8'h02 -> ignored; result 8'h03; outputs held between ops.
REQ-035 rst asserted 3 cycles into RUN -> busy=0, done=0, sum=0 next cycle; a following start of 8'h01+8'h01 completes to 8'h02 normally.
REQ-036 start held high continuously with WIDTH=2, all 16 a/b add combinations -> one done per 3 cycles, sum/cout match a+b (bit0 reproduces half-adder truth table: sum=a^b, carry=a&b).
